// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, operator and state encodings.
// The sequencer and the LCD display logic both decode against these values.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_OP_SET  = 3'd1,
    ST_ENTER_B = 3'd2,
    ST_EXEC    = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_operator(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  function automatic op_e key_to_op(input logic [3:0] k);
    case (k)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad-in / display-out bundle between the calculator sequencer and its host.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic        key_valid;
  logic [3:0]  key_code;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic [2:0]  op;
  logic [15:0] result;
  logic [7:0]  remainder;
  logic        neg;
  logic        result_valid;
  logic        err;
  logic        busy;
  logic        lcd_refresh;

  modport master (
    output key_valid, key_code,
    input  operand_a, operand_b, op, result, remainder, neg,
    input  result_valid, err, busy, lcd_refresh
  );

  modport slave (
    input  key_valid, key_code,
    output operand_a, operand_b, op, result, remainder, neg,
    output result_valid, err, busy, lcd_refresh
  );

endinterface

// File: rtl/calc_div8.sv
// 8-bit restoring divider, one quotient bit per clock, 8 clocks per division.
// The first iteration happens on the start edge so done pulses after the 8th.
module calc_div8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder
);

  logic [7:0] divisor_q;
  logic [2:0] iter_cnt;

  // Returns {remainder, quotient} after shifting in one dividend bit.
  function automatic logic [15:0] restore_step(input logic [7:0] rem_in,
                                               input logic [7:0] quo_in,
                                               input logic [7:0] dvs);
    logic [8:0] shifted;
    logic [8:0] trial;
    shifted = {rem_in, quo_in[7]};
    trial   = shifted - {1'b0, dvs};
    if (trial[8]) return {shifted[7:0], quo_in[6:0], 1'b0};
    else          return {trial[7:0],   quo_in[6:0], 1'b1};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      iter_cnt  <= 3'd0;
      divisor_q <= 8'd0;
      quotient  <= 8'd0;
      remainder <= 8'd0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        busy     <= 1'b0;
        iter_cnt <= 3'd0;
      end else if (start) begin
        {remainder, quotient} <= restore_step(8'd0, dividend, divisor);
        divisor_q <= divisor;
        iter_cnt  <= 3'd1;
        busy      <= 1'b1;
      end else if (busy) begin
        {remainder, quotient} <= restore_step(remainder, quotient, divisor_q);
        iter_cnt <= iter_cnt + 3'd1;
        if (iter_cnt == 3'd7) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: collects two operands and an operator from a key
// strobe stream, runs the arithmetic and drives display-facing status flags.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_OPERAND = 255
) (
  input  logic            clk,
  input  logic            rst,
  calc_sequencer_if.slave bus
);

  localparam logic [11:0] MAX_ENTRY  = 12'(MAX_OPERAND);
  localparam logic [15:0] MAX_RESULT = 16'(MAX_OPERAND);

  state_e             state;
  op_e                op;
  logic [7:0]         operand_a, operand_b, remainder;
  logic [15:0]        result, alu_result;
  logic               neg, result_valid, err, busy, lcd_refresh;
  logic               key_clr, key_digit, key_oper, key_eq;
  logic [11:0]        acc_a, acc_b;
  logic signed [15:0] diff;
  logic               div_start, div_busy, div_done;
  logic [7:0]         div_quo, div_rem;

  // Candidate operand after appending a digit; caller rejects it above MAX_OPERAND.
  function automatic logic [11:0] digit_accum(input logic [7:0] cur, input logic [3:0] digit);
    return ({4'd0, cur} * 12'd10) + {8'd0, digit};
  endfunction

  assign key_clr   = bus.key_valid && (bus.key_code == KEY_CLR);
  assign key_digit = bus.key_valid && is_digit(bus.key_code);
  assign key_oper  = bus.key_valid && is_operator(bus.key_code);
  assign key_eq    = bus.key_valid && (bus.key_code == KEY_EQ);
  assign acc_a     = digit_accum(operand_a, bus.key_code);
  assign acc_b     = digit_accum(operand_b, bus.key_code);
  assign diff      = $signed({8'd0, operand_a}) - $signed({8'd0, operand_b});
  assign div_start = key_eq && (state == ST_ENTER_B) && (op == OP_DIV) && (operand_b != 8'd0);

  always_comb begin
    case (op)
      OP_ADD:  alu_result = {8'd0, operand_a} + {8'd0, operand_b};
      OP_SUB:  alu_result = diff;
      OP_MUL:  alu_result = {8'd0, operand_a} * {8'd0, operand_b};
      default: alu_result = {8'd0, operand_a};
    endcase
  end

  calc_div8 u_div (
    .clk       (clk),
    .rst       (rst),
    .clr       (key_clr),
    .start     (div_start),
    .dividend  (operand_a),
    .divisor   (operand_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_ENTER_A;
      operand_a    <= 8'd0;
      operand_b    <= 8'd0;
      op           <= OP_NONE;
      result       <= 16'd0;
      remainder    <= 8'd0;
      neg          <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      lcd_refresh  <= 1'b0;
    end else begin
      lcd_refresh <= 1'b0;
      if (key_clr) begin
        state        <= ST_ENTER_A;
        operand_a    <= 8'd0;
        operand_b    <= 8'd0;
        op           <= OP_NONE;
        result       <= 16'd0;
        remainder    <= 8'd0;
        neg          <= 1'b0;
        result_valid <= 1'b0;
        err          <= 1'b0;
        busy         <= 1'b0;
        lcd_refresh  <= 1'b1;
      end else begin
        case (state)
          ST_ENTER_A: begin
            if (key_digit && (acc_a <= MAX_ENTRY)) begin
              operand_a   <= acc_a[7:0];
              lcd_refresh <= 1'b1;
            end else if (key_oper) begin
              op          <= key_to_op(bus.key_code);
              state       <= ST_OP_SET;
              lcd_refresh <= 1'b1;
            end else if (key_eq) begin
              result      <= {8'd0, operand_a};
              remainder   <= 8'd0;
              neg         <= 1'b0;
              op          <= OP_NONE;
              state       <= ST_DONE;
              lcd_refresh <= 1'b1;
            end
          end
          ST_OP_SET: begin
            if (key_digit) begin
              operand_b   <= {4'd0, bus.key_code};
              state       <= ST_ENTER_B;
              lcd_refresh <= 1'b1;
            end else if (key_oper) begin
              op          <= key_to_op(bus.key_code);
              lcd_refresh <= 1'b1;
            end
          end
          ST_ENTER_B: begin
            if (key_digit && (acc_b <= MAX_ENTRY)) begin
              operand_b   <= acc_b[7:0];
              lcd_refresh <= 1'b1;
            end else if (key_eq) begin
              lcd_refresh <= 1'b1;
              if ((op == OP_DIV) && (operand_b == 8'd0)) begin
                state <= ST_ERR;
                err   <= 1'b1;
              end else begin
                state <= ST_EXEC;
                busy  <= 1'b1;
              end
            end
          end
          ST_EXEC: begin
            if (op == OP_DIV) begin
              if (div_done) begin
                result      <= {8'd0, div_quo};
                remainder   <= div_rem;
                neg         <= 1'b0;
                state       <= ST_DONE;
                busy        <= 1'b0;
                lcd_refresh <= 1'b1;
              end else if (!div_busy) begin
                // Divider lost its operation without finishing; never wait forever.
                state       <= ST_ERR;
                busy        <= 1'b0;
                err         <= 1'b1;
                lcd_refresh <= 1'b1;
              end
            end else begin
              result      <= alu_result;
              remainder   <= 8'd0;
              neg         <= (op == OP_SUB) && diff[15];
              state       <= ST_DONE;
              busy        <= 1'b0;
              lcd_refresh <= 1'b1;
            end
          end
          ST_DONE: begin
            // result_valid trails DONE entry by one edge and drops on exit.
            result_valid <= 1'b1;
            if (key_digit) begin
              operand_a    <= {4'd0, bus.key_code};
              operand_b    <= 8'd0;
              op           <= OP_NONE;
              result       <= 16'd0;
              remainder    <= 8'd0;
              neg          <= 1'b0;
              state        <= ST_ENTER_A;
              result_valid <= 1'b0;
              lcd_refresh  <= 1'b1;
            end else if (key_oper) begin
              result_valid <= 1'b0;
              lcd_refresh  <= 1'b1;
              if (!neg && (result <= MAX_RESULT)) begin
                operand_a <= result[7:0];
                op        <= key_to_op(bus.key_code);
                state     <= ST_OP_SET;
              end else begin
                state <= ST_ERR;
                err   <= 1'b1;
              end
            end
          end
          ST_ERR: ;
          default: state <= ST_ENTER_A;
        endcase
      end
    end
  end

  assign bus.operand_a    = operand_a;
  assign bus.operand_b    = operand_b;
  assign bus.op           = op;
  assign bus.result       = result;
  assign bus.remainder    = remainder;
  assign bus.neg          = neg;
  assign bus.result_valid = result_valid;
  assign bus.err          = err;
  assign bus.busy         = busy;
  assign bus.lcd_refresh  = lcd_refresh;

endmodule
